// File: rtl/pipe_stage7_writeback_if.sv
// Output beat stream of pipe stage 7: scaled beat data plus valid/ready handshake and beat tags.
// The master side drives the beat; the slave side returns ready_i.
interface pipe_stage7_writeback_if #(
  parameter int WIDTH         = 16,
  parameter int PARALLEL_SIZE = 3,
  parameter int BEAT_ELEMS    = 8,
  parameter int BW            = 4
);
  logic [PARALLEL_SIZE-1:0][BEAT_ELEMS-1:0][WIDTH-1:0] data_o;
  logic                                                 valid_o;
  logic                                                 ready_i;
  logic [BW-1:0]                                        beat_idx_o;
  logic                                                 last_o;

  modport master (
    output data_o,
    output valid_o,
    output beat_idx_o,
    output last_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  beat_idx_o,
    input  last_o,
    output ready_i
  );
endinterface

// File: rtl/pipe_stage7_writeback.sv
// Pipe stage 7: captures a stage-6 tile plus per-lane scales, rescales in fixed point and streams beats out.
// Define PIPE_STAGE7_SAT_EN to saturate the narrowed result instead of wrapping it.
module pipe_stage7_writeback #(
  parameter int WIDTH         = 16,
  parameter int PARALLEL_SIZE = 3,
  parameter int TILE_SIZE     = 128,
  parameter int BEAT_ELEMS    = 8,
  parameter int FRAC_BITS     = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                finished_i,
  input  logic [PARALLEL_SIZE-1:0][TILE_SIZE-1:0][WIDTH-1:0]  acc_i,
  input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                 scal_i,
  pipe_stage7_writeback_if.master                             strm,
  output logic                                                busy_o,
  output logic                                                done_o,
  output logic                                                overrun_o
);
  localparam int NBEATS = TILE_SIZE / BEAT_ELEMS;
  localparam int BW     = $clog2(NBEATS);
  localparam int IW     = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] cnt_reg, cnt_next;
  logic          done_reg, done_next;
  logic          overrun_reg, overrun_next;
  logic          load;
  logic          valid;
  logic          accept;
  logic          last_beat;
  logic [PARALLEL_SIZE-1:0][BEAT_ELEMS-1:0][WIDTH-1:0] beat_data;

  assign valid     = (state_reg == STREAM);
  assign accept    = valid && strm.ready_i;
  assign last_beat = (cnt_reg == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    overrun_next = overrun_reg;
    load         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (finished_i) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (accept && last_beat) begin
          done_next = 1'b1;
          cnt_next  = '0;
          // A tile arriving exactly on the closing edge is taken without a bubble.
          if (finished_i) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (accept) begin
            cnt_next = cnt_reg + 1'b1;
          end
          if (finished_i) begin
            overrun_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < PARALLEL_SIZE; gi++) begin : g_lane
      logic signed [WIDTH-1:0] tile_mem [TILE_SIZE];
      logic signed [WIDTH-1:0] scale_reg;

      // Tile buffers hold data only; they carry no reset.
      always_ff @(posedge clk) begin
        if (load) begin
          for (int i = 0; i < TILE_SIZE; i++) begin
            tile_mem[i] <= acc_i[gi][i];
          end
          scale_reg <= scal_i[gi];
        end
      end

      for (gj = 0; gj < BEAT_ELEMS; gj++) begin : g_elem
        logic [IW-1:0]             elem_idx;
        logic signed [WIDTH-1:0]   elem;
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH-1:0] shifted;
        logic [WIDTH-1:0]          narrowed;
        logic                      unused_bits;

        assign elem_idx = IW'(cnt_reg) * IW'(BEAT_ELEMS) + IW'(gj);
        assign elem     = tile_mem[elem_idx];
        assign prod     = (2*WIDTH)'(elem) * (2*WIDTH)'(scale_reg);
        assign shifted  = prod >>> FRAC_BITS;

`ifdef PIPE_STAGE7_SAT_EN
        localparam logic signed [2*WIDTH-1:0] SAT_MAX = (2*WIDTH)'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
        localparam logic signed [2*WIDTH-1:0] SAT_MIN = ~SAT_MAX;
        always_comb begin
          narrowed = shifted[WIDTH-1:0];
          if (shifted > SAT_MAX) begin
            narrowed = SAT_MAX[WIDTH-1:0];
          end else if (shifted < SAT_MIN) begin
            narrowed = SAT_MIN[WIDTH-1:0];
          end
        end
`else
        assign narrowed = shifted[WIDTH-1:0];
`endif

        // Fraction bits shifted out and sign copies above WIDTH are dropped by design.
        assign unused_bits = ^{prod[FRAC_BITS-1:0], shifted[2*WIDTH-1:WIDTH]};
        assign beat_data[gi][gj] = narrowed;
      end
    end
  endgenerate

  assign strm.data_o     = valid ? beat_data : '0;
  assign strm.valid_o    = valid;
  assign strm.beat_idx_o = cnt_reg;
  assign strm.last_o     = valid && last_beat;
  assign busy_o          = valid;
  assign done_o          = done_reg;
  assign overrun_o       = overrun_reg;
endmodule
